// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} sram_arb_state_t;

  typedef enum logic {OWN_CPU, OWN_DMA} sram_owner_t;

  // Upper SRAM address bits used for the CPU extended-RAM window.
  localparam logic [2:0] CPU_WINDOW_HI = 3'b000;

  // Map a CPU window offset onto the full SRAM address space.
  function automatic logic [17:0] cpu_to_sram(input logic [14:0] i_offset);
    return {CPU_WINDOW_HI, i_offset};
  endfunction

endpackage

// File: rtl/sram_arb_starve.sv
// Grant decision and saturating DMA starvation counter for sram_arbiter.
module sram_arb_starve
  import sram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_idle,
  input  logic        i_cpu_req,
  input  logic        i_dma_req,
  output logic        o_grant,
  output sram_owner_t o_owner,
  output logic [7:0]  o_starve_cnt
);

  logic [7:0] r_cnt;
  logic       w_sat;
  logic       w_dma_win;

  // DMA wins when the CPU is quiet or the CPU has starved it long enough.
  always_comb begin
    w_sat     = (r_cnt == 8'(STARVE_LIMIT));
    w_dma_win = i_dma_req && (!i_cpu_req || w_sat);
    o_grant   = i_idle && (i_dma_req || i_cpu_req);
    o_owner   = w_dma_win ? OWN_DMA : OWN_CPU;
  end

  // Count CPU grants taken while DMA waits; clear once DMA is served or gone.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= 8'd0;
    end else if (i_idle) begin
      if (!i_dma_req || w_dma_win) begin
        r_cnt <= 8'd0;
      end else if (i_cpu_req && !w_sat) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_starve_cnt = r_cnt;

endmodule

// File: rtl/sram_arbiter.sv
// CPU/DMA arbiter for the external SRAM (low byte lane), clocked on clk_vram.
// Optional grant statistics outputs are enabled with `define SRAM_ARB_STATS_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic        clk_vram,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [17:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic [7:0]  dma_rdata,
  output logic        dma_ack,
  output logic [17:0] SRAM_ADDR,
  output logic [7:0]  SRAM_DQ_o,
  output logic        SRAM_DQ_oe,
  input  logic [7:0]  SRAM_DQ_i,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0] cpu_grants,
  output logic [15:0] dma_grants,
  output logic [15:0] forced_grants
`endif
);

  localparam logic [2:0] LAST_ACC = 3'(ACCESS_CYCLES - 1);

  sram_arb_state_t r_state;
  sram_owner_t     r_owner;
  logic            r_we;
  logic [17:0]     r_addr;
  logic [7:0]      r_wdata;
  logic [2:0]      r_acc_cnt;
  logic            r_ce_n, r_oe_n, r_we_n, r_dq_oe;
  logic            r_cpu_ack, r_dma_ack;
  logic [7:0]      r_cpu_rdata, r_dma_rdata;

  logic            w_idle;
  logic            w_grant;
  sram_owner_t     w_owner;
  logic [7:0]      w_starve_cnt;
  logic            w_sel_we;
  logic [17:0]     w_sel_addr;
  logic [7:0]      w_sel_wdata;

  assign w_idle = (r_state == IDLE);

  sram_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .i_clk        (clk_vram),
    .i_reset      (reset),
    .i_idle       (w_idle),
    .i_cpu_req    (cpu_req),
    .i_dma_req    (dma_req),
    .o_grant      (w_grant),
    .o_owner      (w_owner),
    .o_starve_cnt (w_starve_cnt)
  );

  // Select the winning requester's access attributes for registering at grant.
  always_comb begin
    if (w_owner == OWN_DMA) begin
      w_sel_we    = dma_we;
      w_sel_addr  = dma_addr;
      w_sel_wdata = dma_wdata;
    end else begin
      w_sel_we    = cpu_we;
      w_sel_addr  = cpu_to_sram(cpu_addr);
      w_sel_wdata = cpu_wdata;
    end
  end

  // Access FSM; strobes are computed for the next state so every output is a flop.
  always_ff @(posedge clk_vram) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= OWN_CPU;
      r_we        <= 1'b0;
      r_addr      <= 18'd0;
      r_wdata     <= 8'd0;
      r_acc_cnt   <= 3'd0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_cpu_rdata <= 8'd0;
      r_dma_rdata <= 8'd0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner   <= w_owner;
            r_we      <= w_sel_we;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_acc_cnt <= 3'd0;
            r_ce_n    <= 1'b0;
            r_oe_n    <= w_sel_we;
            r_we_n    <= !w_sel_we;
            r_dq_oe   <= w_sel_we;
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          r_acc_cnt <= r_acc_cnt + 3'd1;
          if (r_acc_cnt == LAST_ACC) begin
            if (!r_we) begin
              if (r_owner == OWN_DMA) r_dma_rdata <= SRAM_DQ_i;
              else                    r_cpu_rdata <= SRAM_DQ_i;
            end
            // Release OE/WE but keep CE and write data for hold time.
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_cpu_ack <= (r_owner == OWN_CPU);
            r_dma_ack <= (r_owner == OWN_DMA);
            r_state   <= RECOVER;
          end
        end
        RECOVER: begin
          r_ce_n  <= 1'b1;
          r_dq_oe <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ce_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_we_n  <= 1'b1;
          r_dq_oe <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] r_cpu_grants, r_dma_grants, r_forced_grants;

  // Grant statistics; counters wrap naturally at 16 bits.
  always_ff @(posedge clk_vram) begin
    if (reset) begin
      r_cpu_grants    <= 16'd0;
      r_dma_grants    <= 16'd0;
      r_forced_grants <= 16'd0;
    end else if (w_grant) begin
      if (w_owner == OWN_DMA) begin
        r_dma_grants <= r_dma_grants + 16'd1;
        if (cpu_req) r_forced_grants <= r_forced_grants + 16'd1;
      end else begin
        r_cpu_grants <= r_cpu_grants + 16'd1;
      end
    end
  end

  assign cpu_grants    = r_cpu_grants;
  assign dma_grants    = r_dma_grants;
  assign forced_grants = r_forced_grants;
`endif

  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_ack    = r_cpu_ack;
  assign dma_rdata  = r_dma_rdata;
  assign dma_ack    = r_dma_ack;
  assign SRAM_ADDR  = r_addr;
  assign SRAM_DQ_o  = r_wdata;
  assign SRAM_DQ_oe = r_dq_oe;
  assign SRAM_CE_N  = r_ce_n;
  assign SRAM_OE_N  = r_oe_n;
  assign SRAM_WE_N  = r_we_n;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the external 256Kx16 SRAM (low byte lane only) between two requesters: the CPU extended-RAM window (0x8000-0xFFFF) and a DMA requester that streams memory images into SRAM, such as a snapshot or tape loader.
- Runs on the pixel/VRAM clock, which is much faster than the 3.5 MHz CPU clock, so a CPU access completes well inside one CPU T-state.
- Sequences SRAM strobes, arbitrates by fixed CPU priority, and prevents DMA starvation with a bounded counter.

Parameters:
- ACCESS_CYCLES, 2: clocks the SRAM strobes are held per access; legal range 1..7.
- STARVE_LIMIT, 8: consecutive CPU grants allowed while dma_req is pending before DMA is forced; legal range 1..255.

Ports:
- clk_vram  in  1  single block clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  level; CPU access pending
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  15  offset within the 32K window
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read data; valid while cpu_ack is high, held afterwards
- cpu_ack  out  1  one-cycle completion pulse
- dma_req  in  1  level; DMA access pending
- dma_we  in  1  1 = write
- dma_addr  in  18  full SRAM address
- dma_wdata  in  8  write data
- dma_rdata  out  8  read data; valid while dma_ack is high
- dma_ack  out  1  one-cycle completion pulse
- SRAM_ADDR  out  18
- SRAM_DQ_o  out  8  data to pad
- SRAM_DQ_oe  out  1  pad output enable
- SRAM_DQ_i  in  8  data from pad
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each

Behaviour:
- Reset values:
  - Strobes: SRAM_CE_N=1, SRAM_OE_N=1, SRAM_WE_N=1, SRAM_DQ_oe=0.
  - Acks: cpu_ack=0, dma_ack=0.
  - Data and address: cpu_rdata=0, dma_rdata=0, SRAM_ADDR=0.
  - Internal: starve_cnt=0, state=IDLE.
- States: IDLE -> ACCESS -> RECOVER -> IDLE.
- IDLE:
  - Requests are sampled only in this state.
  - Grant DMA if dma_req && (!cpu_req || starve_cnt==STARVE_LIMIT).
  - Otherwise grant CPU if cpu_req.
  - On grant, register owner, we, address and wdata; go to ACCESS with acc_cnt=0.
  - CPU address is zero-extended: {3'b000, cpu_addr}.
- ACCESS:
  - CE_N=0 for all ACCESS cycles.
  - Read: OE_N=0.
  - Write: WE_N=0 and DQ_oe=1.
  - acc_cnt increments each cycle. When acc_cnt==ACCESS_CYCLES-1, a read captures SRAM_DQ_i into the owner's rdata register; go to RECOVER.
- RECOVER (one cycle):
  - WE_N=1 and OE_N=1; CE_N=0.
  - Write: DQ_oe stays 1 to give data hold time.
  - Owner's ack=1; return to IDLE.
- Latency: grant cycle, plus ACCESS_CYCLES, plus 1. With the default, ack appears 3 clocks after the grant cycle.
- Requesters drop req in the cycle after ack. A req still high in the next IDLE is a new access, which permits back-to-back DMA.
- Strobe hygiene: WE_N and OE_N are never low simultaneously. All outputs are registered.
- Starvation counter (starve_cnt):
  - +1 on each CPU grant while dma_req=1, saturating at STARVE_LIMIT.
  - Cleared on a DMA grant, or in any IDLE cycle with dma_req=0.
- Simultaneous requests: CPU wins unless the counter is saturated.
- Reset mid-access:
  - Next cycle is IDLE with all strobes inactive and DQ_oe=0.
  - No ack is issued; the in-flight write may be partial, which is acceptable.
  - starve_cnt is cleared.
- Address/data changes on the input ports during ACCESS have no effect, because registered copies are used.

Optional Feature:
- Macro SRAM_ARB_STATS_EN.
- When defined:
  - Adds outputs cpu_grants[15:0], dma_grants[15:0] and forced_grants[15:0].
  - Each counter increments on the corresponding grant; forced_grants counts DMA grants made with cpu_req=1.
  - Counters wrap at 0xFFFF to 0 and clear on reset.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package sram_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} sram_arb_state_t
  - typedef enum logic {OWN_CPU, OWN_DMA} sram_owner_t
  - localparam CPU_WINDOW_HI = 3'b000
- One sub-module, sram_arb_starve, holds the saturating starvation counter and the grant-decision logic. The FSM and strobe generation stay in the top module.

Test Plan:
- CPU read, addr 0x1234, SRAM model returns 0xA5 -> SRAM_ADDR=0x01234, OE_N low for 2 clocks, cpu_ack pulses 3 clocks after grant, cpu_rdata=0xA5.
- DMA write, addr 0x3FFFF, data 0x5A -> WE_N low for exactly 2 clocks, DQ_oe high for 3 clocks, model holds 0x5A at 0x3FFFF, dma_ack pulses once.
- cpu_req and dma_req rising in the same cycle, counter 0 -> CPU granted first, then DMA on the next IDLE.
- CPU requesting continuously with DMA pending, STARVE_LIMIT=8 -> 8 CPU grants, then 1 DMA grant, then the counter returns to 0 (forced_grants=1 when stats are enabled).
- reset asserted in the second ACCESS cycle of a write -> next cycle: WE_N=1, DQ_oe=0, no ack; a new CPU read afterwards completes normally.
- With SRAM_ARB_STATS_EN and 65536 CPU grants -> cpu_grants wraps to 0; without the macro the design elaborates with no stats ports.
